hex_entry_input: RTL and testbench
==================================

// Module: hex_entry_input
// PURPOSE
//   Front-panel hex entry for the CPU: the input-side counterpart of the 7-segment readout path.
//   Debounces two active-low push buttons and accumulates four 4-bit switch nibbles into a 16-bit word.
//   Hands the word to the CPU over a valid/ready handshake.
//   echo_out drives the hexTo7Seg decoders while digits are being entered.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  cycles a synchronized button level must stay stable to be accepted (10 ms @ 50 MHz)
//   CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//   TIMEOUT_CYCLES   250000000  idle cycles before a partial entry is discarded (ENTRY_TIMEOUT_EN only)
// PORTS
//   Clk         in   1   system clock, single domain
//   Rst         in   1   synchronous reset, active-low
//   btn_enter   in   1   raw enter key, active-low, asynchronous
//   btn_clear   in   1   raw clear key, active-low, asynchronous
//   sw          in   4   nibble selected on slide switches
//   data_ready  in   1   CPU accepts data_out this cycle
//   data_out    out  16  completed word, stable while data_valid=1
//   data_valid  out  1   word available
//   echo_out    out  16  in-progress shift register, for the display
//   digit_cnt   out  3   digits entered so far, 0..4
// BEHAVIOUR
//   - Reset (Rst=0 at a Clk edge): all outputs 0, state IDLE, sync/debounce flops = released (1), counters 0.
//   - Each button: 2-flop synchronizer, then debounce. Counter increments while the synced level differs from the
//     stable level and clears when they match. At DEBOUNCE_CYCLES-1 the stable level flips and the counter clears.
//   - Press event: 1-cycle pulse on the stable 1->0 transition. No event on release.
//   - Latency: raw edge -> press pulse = 2 + DEBOUNCE_CYCLES cycles. Press pulse -> outputs update next edge.
//   - FSM states: IDLE (digit_cnt=0), COLLECT (1..3 digits), HOLD (4 digits, data_valid=1).
//   - Enter in IDLE/COLLECT: shift <= {shift[11:0], sw}; digit_cnt++. Goes to COLLECT, or to HOLD on the 4th digit.
//     In HOLD, data_out <= the completed shift value.
//   - Enter in HOLD is ignored. The nibble is dropped and nothing changes.
//   - Handshake: transfer occurs when data_valid & data_ready are both 1 at an edge.
//     On that edge: -> IDLE, data_valid=0, shift=0, digit_cnt=0. data_out keeps its last value.
//   - data_ready while data_valid=0 is ignored. data_valid never drops without a transfer, clear, or reset.
//   - Clear press in any state: -> IDLE, shift=0, digit_cnt=0, data_valid=0.
//   - Simultaneous events: clear beats enter. A transfer on the same edge as a clear still counts as completed.
//   - Reset mid-entry or mid-HOLD discards the word with no transfer.
//   - echo_out = shift at all times. In HOLD it equals data_out.
// CONFIGURATION
//   ENTRY_TIMEOUT_EN defined:
//     - In COLLECT, an idle counter increments each cycle and clears on every enter press.
//     - When it reaches TIMEOUT_CYCLES-1: same action as clear.
//     - Not active in IDLE or HOLD.
//   ENTRY_TIMEOUT_EN undefined: no idle counter; a partial entry persists indefinitely.
// STRUCTURE
//   Package hex_entry_pkg:
//     - state encoding IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2
//     - NUM_DIGITS=4, NIBBLE_W=4, WORD_W=16
//   Sub-module btn_debounce, instantiated twice:
//     - contains synchronizer + counter
//     - parameters DEBOUNCE_CYCLES and CNT_W
//     - ports Clk, Rst, btn_raw, btn_stable, press_pulse
//   Top module holds the FSM, shift register, output register and the optional timeout counter.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50 in simulation)
//   1. Rst=0 for 1 edge with buttons released -> data_out=0, data_valid=0, echo_out=0, digit_cnt=0.
//   2. data_ready=0; enter with sw=1,2,3,4 -> digit_cnt 1..4, then data_valid=1, data_out=16'h1234.
//      Extra enter with sw=F -> data_out unchanged.
//   3. From 2, data_ready=1 for one cycle -> data_valid=0 next edge, digit_cnt=0, echo_out=0, data_out=16'h1234.
//   4. btn_enter low for 3 cycles (< DEBOUNCE_CYCLES) -> no digit.
//      Held low for 10 cycles -> exactly one digit, none on release.
//   5. Enter A,B, then clear -> echo_out=0.
//      Then enter C,D,E,F -> data_out=16'hCDEF.
//      Enter and clear pressed on the same cycle -> state IDLE, no digit.
//   6. With ENTRY_TIMEOUT_EN: enter 7, wait 50 cycles -> digit_cnt=0, echo_out=0.
//      Without the macro -> echo_out=16'h0007 after 1000 cycles.

Source files
------------

// File: rtl/hex_entry_pkg.sv
// Shared definitions for the front-panel hex entry block: entry FSM states and word geometry.
package hex_entry_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int WORD_W     = NUM_DIGITS * NIBBLE_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } entry_state_t;

endpackage

// File: rtl/hex_entry_input_btn_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low push button.
// press_pulse fires for one cycle when the accepted level falls from released to pressed.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic Clk,
    input  logic Rst,
    input  logic btn_raw,
    output logic btn_stable,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // The counter only runs while the synced level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the qualification window.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync_1      <= 1'b1;
            sync_2      <= 1'b1;
            btn_stable  <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_1      <= btn_raw;
            sync_2      <= sync_1;
            press_pulse <= 1'b0;
            if (sync_2 == btn_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_stable  <= sync_2;
                cnt         <= '0;
                press_pulse <= ~sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_entry_input.sv
// Front-panel hex entry: debounced enter/clear keys build a 16-bit word from four switch nibbles,
// offered to the CPU over valid/ready. Optional partial-entry timeout under ENTRY_TIMEOUT_EN.
import hex_entry_pkg::*;

module hex_entry_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                btn_enter,
    input  logic                btn_clear,
    input  logic [NIBBLE_W-1:0] sw,
    input  logic                data_ready,
    output logic [WORD_W-1:0]   data_out,
    output logic                data_valid,
    output logic [WORD_W-1:0]   echo_out,
    output logic [2:0]          digit_cnt
);

    entry_state_t      state, state_next;
    logic [WORD_W-1:0] shift, shift_next;
    logic [WORD_W-1:0] data_next;
    logic [2:0]        cnt_next;
    logic              enter_press, clear_press;
    logic              enter_stable, clear_stable;
    logic              unused_stable;
    logic              timeout;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter_db (
        .Clk(Clk), .Rst(Rst), .btn_raw(btn_enter),
        .btn_stable(enter_stable), .press_pulse(enter_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear_db (
        .Clk(Clk), .Rst(Rst), .btn_raw(btn_clear),
        .btn_stable(clear_stable), .press_pulse(clear_press)
    );

    assign unused_stable = enter_stable & clear_stable;

`ifdef ENTRY_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] idle_cnt;

    assign timeout = (state == COLLECT) && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Idle time is only measured while a partial entry is pending.
    always_ff @(posedge Clk) begin
        if (!Rst || state != COLLECT || enter_press || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Priority: clear (or timeout) first, then a completed transfer, then a new digit.
    always_comb begin
        state_next = state;
        shift_next = shift;
        cnt_next   = digit_cnt;
        data_next  = data_out;
        if (clear_press || timeout) begin
            state_next = IDLE;
            shift_next = '0;
            cnt_next   = '0;
        end else if (state == HOLD && data_ready) begin
            state_next = IDLE;
            shift_next = '0;
            cnt_next   = '0;
        end else if (enter_press && state != HOLD) begin
            shift_next = {shift[WORD_W-NIBBLE_W-1:0], sw};
            cnt_next   = digit_cnt + 3'd1;
            if (digit_cnt == 3'(NUM_DIGITS - 1)) begin
                state_next = HOLD;
                data_next  = {shift[WORD_W-NIBBLE_W-1:0], sw};
            end else begin
                state_next = COLLECT;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            shift     <= '0;
            digit_cnt <= '0;
            data_out  <= '0;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            digit_cnt <= cnt_next;
            data_out  <= data_next;
        end
    end

    assign data_valid = (state == HOLD);
    assign echo_out   = shift;

endmodule

// File: tb/tb_hex_entry_input.sv
// Directed bench for hex_entry_input with a cycle-level behavioural model; honours ENTRY_TIMEOUT_EN.
module tb_hex_entry_input;

    localparam int D_CYC  = 4;
    localparam int T_CYC  = 50;
    localparam int SETTLE = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_enter = 1'b1;
    logic        btn_clear = 1'b1;
    logic [3:0]  sw = 4'h0;
    logic        data_ready = 1'b0;
    logic [15:0] data_out;
    logic        data_valid;
    logic [15:0] echo_out;
    logic [2:0]  digit_cnt;

    int checks = 0;
    int fails  = 0;

    hex_entry_input #(.DEBOUNCE_CYCLES(D_CYC), .CNT_W(3), .TIMEOUT_CYCLES(T_CYC)) dut (
        .Clk(clk), .Rst(rst_n), .btn_enter(btn_enter), .btn_clear(btn_clear),
        .sw(sw), .data_ready(data_ready), .data_out(data_out), .data_valid(data_valid),
        .echo_out(echo_out), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    // Model state: word under construction, digits so far, valid flag, last delivered word.
    int          m_word, m_cnt, m_data, m_idle;
    bit          m_valid, model_live;
    bit          stab_e, stab_c, pend_e, pend_c;
    logic [31:0] hist_e, hist_c;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // True when the synchronized samples over the last D_CYC edges all held level v.
    function automatic bit window_all(input logic [31:0] h, input logic v);
        for (int j = 1; j <= D_CYC; j++)
            if (h[j] != v) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        model_live = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_word = 0; m_cnt = 0; m_data = 0; m_idle = 0; m_valid = 1'b0;
                stab_e = 1'b1; stab_c = 1'b1; pend_e = 1'b0; pend_c = 1'b0;
                hist_e = '1; hist_c = '1;
                model_live = 1'b1;
            end else begin
                bit tmo;
                tmo = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
                if (m_cnt > 0 && !m_valid) begin
                    tmo = (m_idle == T_CYC - 1);
                    m_idle = (pend_e || tmo) ? 0 : m_idle + 1;
                end else begin
                    m_idle = 0;
                end
`endif
                if (pend_c || tmo || (m_valid && data_ready)) begin
                    m_word = 0; m_cnt = 0; m_valid = 1'b0;
                end else if (pend_e && !m_valid) begin
                    m_word = ((m_word << 4) | int'(sw)) & 16'hFFFF;
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_valid = 1'b1;
                        m_data  = m_word;
                    end
                end
                pend_e = 1'b0;
                if (window_all(hist_e, ~stab_e)) begin
                    stab_e = ~stab_e;
                    pend_e = !stab_e;
                end
                pend_c = 1'b0;
                if (window_all(hist_c, ~stab_c)) begin
                    stab_c = ~stab_c;
                    pend_c = !stab_c;
                end
                hist_e = {hist_e[30:0], btn_enter};
                hist_c = {hist_c[30:0], btn_clear};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                checkOutput("cyc data_out",   int'(data_out),   m_data);
                checkOutput("cyc data_valid", int'(data_valid), int'(m_valid));
                checkOutput("cyc echo_out",   int'(echo_out),   m_word);
                checkOutput("cyc digit_cnt",  int'(digit_cnt),  m_cnt);
            end
        end
    end

    task automatic applyStimulus(input bit enter, input bit clear, input logic [3:0] nib, input int hold);
        @(negedge clk);
        sw = nib;
        btn_enter = ~enter;
        btn_clear = ~clear;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        repeat (SETTLE) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset data_out",   int'(data_out),   0);
        checkOutput("reset data_valid", int'(data_valid), 0);
        checkOutput("reset echo_out",   int'(echo_out),   0);
        checkOutput("reset digit_cnt",  int'(digit_cnt),  0);

        applyStimulus(1, 0, 4'h1, 10);
        checkOutput("digit1 cnt", int'(digit_cnt), 1);
        applyStimulus(1, 0, 4'h2, 10);
        checkOutput("digit2 cnt", int'(digit_cnt), 2);
        applyStimulus(1, 0, 4'h3, 10);
        checkOutput("digit3 cnt", int'(digit_cnt), 3);
        checkOutput("digit3 echo", int'(echo_out), 16'h0123);
        applyStimulus(1, 0, 4'h4, 10);
        checkOutput("digit4 cnt", int'(digit_cnt), 4);
        checkOutput("hold valid", int'(data_valid), 1);
        checkOutput("hold data", int'(data_out), 16'h1234);
        applyStimulus(1, 0, 4'hF, 10);
        checkOutput("extra enter data", int'(data_out), 16'h1234);
        checkOutput("extra enter echo", int'(echo_out), 16'h1234);

        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        checkOutput("xfer valid", int'(data_valid), 0);
        checkOutput("xfer cnt", int'(digit_cnt), 0);
        checkOutput("xfer echo", int'(echo_out), 0);
        checkOutput("xfer data kept", int'(data_out), 16'h1234);
        @(negedge clk);
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        data_ready = 1'b0;
        checkOutput("idle ready ignored", int'(data_valid), 0);

        @(negedge clk);
        sw = 4'h9;
        btn_enter = 1'b0;
        repeat (3) @(negedge clk);
        btn_enter = 1'b1;
        repeat (SETTLE) @(negedge clk);
        checkOutput("short press", int'(digit_cnt), 0);
        applyStimulus(1, 0, 4'h5, 10);
        checkOutput("long press cnt", int'(digit_cnt), 1);
        checkOutput("long press echo", int'(echo_out), 16'h0005);
        applyStimulus(0, 1, 4'h0, 10);
        checkOutput("clear cnt", int'(digit_cnt), 0);

        applyStimulus(1, 0, 4'hA, 10);
        applyStimulus(1, 0, 4'hB, 10);
        checkOutput("AB echo", int'(echo_out), 16'h00AB);
        applyStimulus(0, 1, 4'h0, 10);
        checkOutput("AB cleared", int'(echo_out), 0);
        applyStimulus(1, 0, 4'hC, 10);
        applyStimulus(1, 0, 4'hD, 10);
        applyStimulus(1, 0, 4'hE, 10);
        applyStimulus(1, 0, 4'hF, 10);
        checkOutput("CDEF data", int'(data_out), 16'hCDEF);
        checkOutput("CDEF valid", int'(data_valid), 1);
        applyStimulus(1, 1, 4'h6, 10);
        checkOutput("both from hold valid", int'(data_valid), 0);
        checkOutput("both from hold cnt", int'(digit_cnt), 0);
        applyStimulus(1, 1, 4'h6, 10);
        checkOutput("both from idle cnt", int'(digit_cnt), 0);
        checkOutput("both from idle echo", int'(echo_out), 0);

        applyStimulus(1, 0, 4'h7, 10);
`ifdef ENTRY_TIMEOUT_EN
        repeat (45) @(negedge clk);
        checkOutput("timeout cnt", int'(digit_cnt), 0);
        checkOutput("timeout echo", int'(echo_out), 0);
`else
        repeat (1000) @(negedge clk);
        checkOutput("persist echo", int'(echo_out), 16'h0007);
        checkOutput("persist cnt", int'(digit_cnt), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
